// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte-wide register file and local read port.
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample SCL/SDA agreement filter.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;
    localparam logic [8:0] DEPTH9      = 9'(DEPTH);

    logic          scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic          scl_f, sda_f, scl_l_q, sda_l_q;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]    state_q, state_d, cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d, tx_q, tx_d, byte_in, rd_byte;
    logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic          rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [7:0]    wr_data_q, wr_data_d, rd_data_q;
    logic [7:0]    regs_q [DEPTH];

    // Two-flop synchronizers; the idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic scl_h1_q, scl_h2_q, sda_h1_q, sda_h2_q;

    // Sample history; the level moves only when three samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h1_q <= 1'b1;
            scl_h2_q <= 1'b1;
            sda_h1_q <= 1'b1;
            sda_h2_q <= 1'b1;
        end else begin
            scl_h1_q <= scl_s2_q;
            scl_h2_q <= scl_h1_q;
            sda_h1_q <= sda_s2_q;
            sda_h2_q <= sda_h1_q;
        end
    end

    assign scl_f = (scl_s2_q == scl_h1_q && scl_h1_q == scl_h2_q) ? scl_s2_q : scl_l_q;
    assign sda_f = (sda_s2_q == sda_h1_q && sda_h1_q == sda_h2_q) ? sda_s2_q : sda_l_q;
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    // Previous bus levels for edge and condition detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_l_q <= 1'b1;
            sda_l_q <= 1'b1;
        end else begin
            scl_l_q <= scl_f;
            sda_l_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_l_q;
    assign scl_fall  = ~scl_f & scl_l_q;
    assign start_det = scl_f & scl_l_q & ~sda_f & sda_l_q;
    assign stop_det  = scl_f & scl_l_q & sda_f & ~sda_l_q;
    assign byte_in   = {sr_q[6:0], sda_f};
    assign rd_byte   = regs_q[ptr_q];

    // Protocol FSM: bus conditions first, then bit shifting and SDA driving.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        unique case (1'b1)
            start_det: begin
                state_d  = S_ADDR;
                cnt_d    = '0;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            stop_det: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            scl_rise: begin
                sr_d  = byte_in;
                cnt_d = cnt_q + 4'd1;
                unique case (state_q)
                    S_ADDR: if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (byte_in[7:1] == TGT_ADDR) begin
                            state_d = S_ADDR_ACK;
                            rw_d    = byte_in[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                    S_PTR: if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if ({1'b0, byte_in} < DEPTH9) begin
                            ptr_d   = byte_in[AW-1:0];
                            state_d = S_PTR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                    S_WDATA: if (cnt_q == 4'd7) begin
                        cnt_d       = '0;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + AW'(1);
                        state_d     = S_WDATA_ACK;
                    end
                    S_RDATA: ;
                    S_RACK: begin
                        cnt_d = cnt_q;
                        if (!sda_f) begin
                            cnt_d = 4'd9;
                            ptr_d = ptr_q + AW'(1);
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                    default: cnt_d = cnt_q;
                endcase
            end
            scl_fall: begin
                unique case (state_q)
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            if (state_q != S_ADDR_ACK) begin
                                state_d = S_WDATA;
                            end else if (!rw_q) begin
                                state_d = S_PTR;
                            end else begin
                                state_d  = S_RDATA;
                                sda_oe_d = ~rd_byte[7];
                                tx_d     = {rd_byte[6:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA: begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                    S_RACK: if (cnt_q == 4'd9) begin
                        state_d  = S_RDATA;
                        cnt_d    = '0;
                        sda_oe_d = ~rd_byte[7];
                        tx_d     = {rd_byte[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file, written only from the I2C side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_strobe_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Local read port with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= regs_q[rd_addr];
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_data   = rd_data_q;
endmodule
